sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/dsm_pkg.sv | 17 +
 rtl/sample_fifo.sv | 69 ++++++
 rtl/sample_feeder.sv | 136 +++++++++++++
 tb/tb_sample_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma path: feeder state encoding and the
// sample width used by both the feeder and the modulator.
package dsm_pkg;

    localparam int DSM_IN_BITS = 12;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PLAY    = 2'd1,
        STARVED = 2'd2
    } feeder_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO with a combinational head read, so a pop and the capture of
// the popped value land on the same edge. Contents are discarded on reset.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == COUNT_FULL);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count_reg;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// Rate-paced sample feeder: buffers producer samples and releases one every DIV
// clocks to the modulator. Define SAMPLE_FEEDER_UNDERFLOW_COUNT_EN for a saturating underflow counter.
module sample_feeder
    import dsm_pkg::*;
#(
    parameter int IN_BITS = DSM_IN_BITS,
    parameter int DEPTH   = 8,
    parameter int DIV     = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_BITS-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [IN_BITS-1:0] sample,
    output logic               sample_stb,
    output logic               underflow
`ifdef SAMPLE_FEEDER_UNDERFLOW_COUNT_EN
    ,
    output logic [15:0]        underflow_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0]      DIV_LAST  = DW'(DIV - 1);
    localparam logic [CW-1:0]      HALF_FULL = CW'(DEPTH / 2);
    localparam logic [IN_BITS-1:0] MIDSCALE  = IN_BITS'(1) << (IN_BITS - 1);

    feeder_state_t      state_reg;
    feeder_state_t      state_next;
    logic [DW-1:0]      div_reg;
    logic [DW-1:0]      div_next;
    logic [IN_BITS-1:0] sample_reg;
    logic [IN_BITS-1:0] sample_next;
    logic               stb_reg;
    logic               stb_next;
    logic               underflow_reg;
    logic               underflow_next;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [IN_BITS-1:0] fifo_rdata;
    logic               tick;

    // in_ready comes only from registered occupancy, never from in_valid.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign tick      = (state_reg == PLAY) && (div_reg == DIV_LAST);
    assign fifo_pop  = tick && !fifo_empty;

    sample_fifo #(
        .WIDTH (IN_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next     = state_reg;
        div_next       = DIV_LAST;
        sample_next    = sample_reg;
        stb_next       = fifo_pop;
        underflow_next = 1'b0;
        unique case (state_reg)
            FILL: begin
                if (fifo_count >= HALF_FULL) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                div_next = (div_reg == '0) ? DIV_LAST : div_reg - DW'(1);
                // A same-cycle push is not visible here: empty means starve.
                if (tick && fifo_empty) begin
                    state_next     = STARVED;
                    underflow_next = 1'b1;
                end
            end
            STARVED: begin
                state_next = FILL;
            end
            default: begin
                state_next = FILL;
            end
        endcase
        if (fifo_pop) begin
            sample_next = fifo_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= FILL;
            div_reg       <= DIV_LAST;
            sample_reg    <= MIDSCALE;
            stb_reg       <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            sample_reg    <= sample_next;
            stb_reg       <= stb_next;
            underflow_reg <= underflow_next;
        end
    end

    assign sample     = sample_reg;
    assign sample_stb = stb_reg;
    assign underflow  = underflow_reg;

`ifdef SAMPLE_FEEDER_UNDERFLOW_COUNT_EN
    logic [15:0] underflow_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_cnt_reg <= '0;
        end else if (underflow_reg) begin
            underflow_cnt_reg <= sat_inc16(underflow_cnt_reg);
        end
    end

    assign underflow_count = underflow_cnt_reg;
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder (IN_BITS=12, DEPTH=4, DIV=4).
module tb_sample_feeder;
    import dsm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] sample;
    logic        sample_stb;
    logic        underflow;
`ifdef SAMPLE_FEEDER_UNDERFLOW_COUNT_EN
    logic [15:0] underflow_count;
`endif

    int checks = 0;
    int failures = 0;

    sample_feeder #(
        .IN_BITS (12),
        .DEPTH   (4),
        .DIV     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sample     (sample),
        .sample_stb (sample_stb),
        .underflow  (underflow)
`ifdef SAMPLE_FEEDER_UNDERFLOW_COUNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int events;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();
        checks++; if (sample !== 12'h800) begin failures++; $display("FAIL reset_sample actual=%h expected=800", sample); end
        checks++; if (sample_stb !== 1'b0) begin failures++; $display("FAIL reset_stb actual=%b expected=0", sample_stb); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow actual=%b expected=0", underflow); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b expected=1", in_ready); end
        rst = 1'b1;
        events = 0;
        repeat (10) begin
            step();
            if (sample_stb !== 1'b0 || underflow !== 1'b0) events++;
        end
        checks++; if (events != 0) begin failures++; $display("FAIL idle_events actual=%0d expected=0", events); end
        checks++; if (dut.state_reg !== FILL) begin failures++; $display("FAIL idle_state actual=%0d expected=%0d", dut.state_reg, FILL); end
        checks++; if (sample !== 12'h800) begin failures++; $display("FAIL idle_sample actual=%h expected=800", sample); end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_prefill_rate();
        int first_k;
        int second_k;
        logic [11:0] s1;
        logic [11:0] s2;
        first_k = -1; second_k = -1; s1 = '0; s2 = '0;
        in_valid = 1'b1; in_data = 12'h001;
        step();
        in_data = 12'h002;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                checks++; if (dut.state_reg !== PLAY) begin failures++; $display("FAIL play_entered actual=%0d expected=%0d", dut.state_reg, PLAY); end
            end
            if (sample_stb === 1'b1) begin
                if (first_k < 0) begin first_k = k; s1 = sample; end
                else if (second_k < 0) begin second_k = k; s2 = sample; end
            end
        end
        checks++; if (first_k != 2) begin failures++; $display("FAIL first_stb_cycle actual=%0d expected=2", first_k); end
        checks++; if (s1 !== 12'h001) begin failures++; $display("FAIL first_sample actual=%h expected=001", s1); end
        checks++; if (second_k != 6) begin failures++; $display("FAIL second_stb_cycle actual=%0d expected=6", second_k); end
        checks++; if (s2 !== 12'h002) begin failures++; $display("FAIL second_sample actual=%h expected=002", s2); end
        $display("test_prefill_rate stb at %0d and %0d samples %h %h", first_k, second_k, s1, s2);
    endtask

    task automatic test_underflow();
        int uf_k;
        int uf_n;
        int stbs;
        uf_k = -1; uf_n = 0; stbs = 0;
        for (int k = 7; k <= 14; k++) begin
            step();
            if (underflow === 1'b1) begin
                uf_n++;
                if (uf_k < 0) uf_k = k;
            end
            if (sample_stb === 1'b1) stbs++;
            if (k == 10) begin
                checks++; if (dut.state_reg !== STARVED) begin failures++; $display("FAIL starved_state actual=%0d expected=%0d", dut.state_reg, STARVED); end
            end
            if (k == 11) begin
                checks++; if (dut.state_reg !== FILL) begin failures++; $display("FAIL refill_state actual=%0d expected=%0d", dut.state_reg, FILL); end
            end
        end
        checks++; if (uf_k != 10) begin failures++; $display("FAIL underflow_cycle actual=%0d expected=10", uf_k); end
        checks++; if (uf_n != 1) begin failures++; $display("FAIL underflow_pulses actual=%0d expected=1", uf_n); end
        checks++; if (stbs != 0) begin failures++; $display("FAIL underflow_stb actual=%0d expected=0", stbs); end
        checks++; if (sample !== 12'h002) begin failures++; $display("FAIL underflow_hold actual=%h expected=002", sample); end
        $display("test_underflow pulse at %0d count %0d", uf_k, uf_n);
    endtask

    task automatic test_back_to_back();
        logic [11:0] got [4];
        int n;
        int uf_k;
        for (int i = 0; i < 4; i++) got[i] = '0;
        n = 0; uf_k = -1;
        // Prime so that one entry remains when the pushes begin.
        in_valid = 1'b1; in_data = 12'h0A0;
        step();
        in_data = 12'h0A1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        in_valid = 1'b1; in_data = 12'h010;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_start actual=%b expected=1", in_ready); end
        step();
        checks++; if (sample_stb !== 1'b1 || sample !== 12'h0A1) begin failures++; $display("FAIL b2b_prime_pop actual=%b/%h expected=1/0a1", sample_stb, sample); end
        in_data = 12'h011;
        step();
        in_data = 12'h012;
        step();
        in_data = 12'h013;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_before_4th actual=%b expected=1", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full actual=%b expected=0", in_ready); end
        in_data = 12'h014;
        step();
        checks++; if (sample_stb !== 1'b1 || sample !== 12'h010) begin failures++; $display("FAIL b2b_pop_head actual=%b/%h expected=1/010", sample_stb, sample); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_on_pop actual=%b expected=1", in_ready); end
        in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (sample_stb === 1'b1) begin
                if (n < 4) got[n] = sample;
                n++;
            end
            if (underflow === 1'b1 && uf_k < 0) uf_k = k;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL b2b_drain_count actual=%0d expected=3", n); end
        checks++; if (got[0] !== 12'h011 || got[1] !== 12'h012 || got[2] !== 12'h013) begin failures++; $display("FAIL b2b_order actual=%h %h %h expected=011 012 013", got[0], got[1], got[2]); end
        checks++; if (uf_k != 16) begin failures++; $display("FAIL b2b_underflow_cycle actual=%0d expected=16", uf_k); end
        repeat (2) step();
        $display("test_back_to_back drained %0d samples, underflow at %0d", n, uf_k);
    endtask

    task automatic test_midreset();
        int stbs;
        int uf_k;
        stbs = 0; uf_k = -1;
        in_valid = 1'b1; in_data = 12'h0B0;
        step();
        in_data = 12'h0B1;
        step();
        in_data = 12'h0B2;
        step();
        in_data = 12'h0B3;
        step();
        in_valid = 1'b0;
        checks++; if (sample_stb !== 1'b1 || sample !== 12'h0B0) begin failures++; $display("FAIL mid_pre_pop actual=%b/%h expected=1/0b0", sample_stb, sample); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (sample !== 12'h800) begin failures++; $display("FAIL mid_async_sample actual=%h expected=800", sample); end
        checks++; if (dut.u_fifo.empty !== 1'b1) begin failures++; $display("FAIL mid_fifo_empty actual=%b expected=1", dut.u_fifo.empty); end
        checks++; if (sample_stb !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_outputs actual=%b/%b expected=0/1", sample_stb, in_ready); end
        repeat (2) step();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 12'h0C0;
        step();
        in_valid = 1'b0;
        repeat (8) begin
            step();
            if (sample_stb === 1'b1) stbs++;
        end
        checks++; if (stbs != 0) begin failures++; $display("FAIL mid_one_push_stb actual=%0d expected=0", stbs); end
        in_valid = 1'b1; in_data = 12'h0C1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (sample_stb !== 1'b1 || sample !== 12'h0C0) begin failures++; $display("FAIL mid_fresh_sample actual=%b/%h expected=1/0c0", sample_stb, sample); end
        for (int k = 1; k <= 12 && uf_k < 0; k++) begin
            step();
            if (underflow === 1'b1) uf_k = k;
        end
        checks++; if (uf_k != 8) begin failures++; $display("FAIL mid_drain_underflow actual=%0d expected=8", uf_k); end
        repeat (2) step();
        $display("test_midreset done underflow at %0d", uf_k);
    endtask

`ifdef SAMPLE_FEEDER_UNDERFLOW_COUNT_EN
    task automatic test_counter_sat();
        checks++; if (underflow_count !== 16'd1) begin failures++; $display("FAIL cnt_after_reset actual=%h expected=0001", underflow_count); end
        dut.underflow_cnt_reg = 16'hFFFD;
        repeat (3) begin
            in_valid = 1'b1; in_data = 12'h0D0;
            step();
            in_data = 12'h0D1;
            step();
            in_valid = 1'b0;
            repeat (11) step();
        end
        checks++; if (underflow_count !== 16'hFFFF) begin failures++; $display("FAIL cnt_saturate actual=%h expected=ffff", underflow_count); end
        $display("test_counter_sat count=%h", underflow_count);
    endtask
`endif

    initial begin
        test_reset();
        test_prefill_rate();
        test_underflow();
        test_back_to_back();
        test_midreset();
`ifdef SAMPLE_FEEDER_UNDERFLOW_COUNT_EN
        test_counter_sat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

endmodule
